pc_control_unit: RTL

//   Parametrised next-PC / branch-control block for the RISC CPU fetch stage.

---
 rtl/pc_control_unit_if.sv | 36 +++
 rtl/pc_control_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pc_control_unit_if.sv
// Fetch-stage control bundle: branch-resolution inputs from the CPU core, and the
// PC/flush/return-stack status driven back by pc_control_unit.
interface pc_control_unit_if #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             br_valid;
  logic [1:0]       bs;
  logic             ps;
  logic             z;
  logic [PC_W-1:0]  bra;
  logic [PC_W-1:0]  raa;
  logic [PC_W-1:0]  pc_1;
  logic [1:0]       ras_op;

  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             taken;
  logic             squash;
  logic [CNT_W-1:0] ras_count;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, br_valid, bs, ps, z, bra, raa, pc_1, ras_op,
    input  pc, pc_valid, taken, squash, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, br_valid, bs, ps, z, bra, raa, pc_1, ras_op,
    output pc, pc_valid, taken, squash, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_control_unit.sv
// Next-PC / branch control for the fetch stage: PC register, BS/PS/Z redirect,
// circular return-address stack, stall hold and a post-redirect squash window.
module pc_control_unit #(
  parameter int              PC_W         = 32,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int              FLUSH_SLOTS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  pc_control_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int FC_W  = $clog2(FLUSH_SLOTS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_SLOTS);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t           state;
  logic [PC_W-1:0]  pc_q;
  logic             pc_valid_q;
  logic             taken_q;
  logic             squash_q;
  logic [FC_W-1:0]  flush_cnt;
  logic [CNT_W-1:0] ras_cnt;
  logic [PTR_W-1:0] ras_sp;
  logic             ovf_q;
  logic             unf_q;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  logic             active;
  logic             take;
  logic             do_push;
  logic             do_pop;
  logic [PC_W-1:0]  target;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] sp_inc;
  logic [FC_W-1:0]  flush_nxt;

  // ras_sp is the next write slot; the stack wraps so a push when full drops the oldest entry
  assign active  = (state != BOOT) && !bus.stall;
  assign top_idx = (ras_sp == '0) ? PTR_LAST : ras_sp - PTR_W'(1);
  assign sp_inc  = (ras_sp == PTR_LAST) ? '0 : ras_sp + PTR_W'(1);

  always_comb begin
    take    = 1'b0;
    target  = bus.bra;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (bus.br_valid) begin
      unique case (bus.bs)
        2'b01:   take = (bus.z == bus.ps);
        2'b10: begin
          take   = 1'b1;
          target = bus.raa;
        end
        2'b11:   take = 1'b1;
        default: take = 1'b0;
      endcase
      // A return overrides BS; an empty stack falls back to the register address
      if (bus.ras_op == 2'b10) begin
        take   = 1'b1;
        do_pop = 1'b1;
        target = (ras_cnt == '0) ? bus.raa : ras_mem[top_idx];
      end
      if (bus.ras_op == 2'b01) do_push = 1'b1;
    end
  end

  always_comb begin
    flush_nxt = '0;
    if (take)                 flush_nxt = FLUSH_LOAD;
    else if (flush_cnt != '0) flush_nxt = flush_cnt - FC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      squash_q   <= 1'b0;
      flush_cnt  <= '0;
      ras_cnt    <= '0;
      ras_sp     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (bus.stall) begin
      taken_q <= 1'b0;
    end else if (state == BOOT) begin
      state      <= RUN;
      pc_valid_q <= 1'b1;
      taken_q    <= 1'b0;
    end else begin
      pc_q      <= take ? target : pc_q + PC_W'(1);
      taken_q   <= take;
      flush_cnt <= flush_nxt;
      squash_q  <= (flush_nxt != '0);
      state     <= (flush_nxt != '0) ? FLUSH : RUN;
      if (do_pop) begin
        if (ras_cnt == '0) begin
          unf_q <= 1'b1;
        end else begin
          ras_cnt <= ras_cnt - CNT_W'(1);
          ras_sp  <= top_idx;
        end
      end
      if (do_push) begin
        ras_sp <= sp_inc;
        if (ras_cnt == CNT_FULL) ovf_q   <= 1'b1;
        else                     ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (active && do_push) ras_mem[ras_sp] <= bus.pc_1;
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.taken     = taken_q;
  assign bus.squash    = squash_q;
  assign bus.ras_count = ras_cnt;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule
